// File: rtl/sdm_dac_mc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdm_pkg
// Description : Shared types and arithmetic helpers for the multi-channel
//               sigma-delta DAC modulator (loop order, FSM states, full-scale
//               feedback constant, saturating integrator add).
// Revision    : 1.0  initial release
// ============================================================================
package sdm_pkg;

    typedef enum int {
        SDM_ORD1 = 1,
        SDM_ORD2 = 2
    } sdm_order_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sdm_state_e;

    // Magnitude of the 1-bit DAC feedback: 2^(data_w-1).
    function automatic longint sdm_fs(input int data_w);
        return longint'(1) <<< (data_w - 1);
    endfunction

    // Add in 64 bits (never wraps for any practical ACC_W) and clip the
    // result to the signed acc_w-bit range.
    function automatic longint sdm_sat_add(input longint a, input longint b,
                                           input int acc_w);
        longint hi;
        longint lo;
        longint s;
        hi = (longint'(1) <<< (acc_w - 1)) - 1;
        lo = -hi - 1;
        s  = a + b;
        if (s > hi) begin
            return hi;
        end
        if (s < lo) begin
            return lo;
        end
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdm_dac_mc_if.sv
`default_nettype none
// ============================================================================
// Module      : sdm_dac_mc_if
// Description : PCM frame handshake between the audio sample source and the
//               sigma-delta modulator.
//   valid_in : frame on audio_in is valid (source -> modulator)
//   ready_in : modulator can accept a frame this cycle (modulator -> source)
//   audio_in : NUM_CH signed samples, channel c at [c*DATA_W +: DATA_W]
// Revision    : 1.0  initial release
// ============================================================================
interface sdm_dac_mc_if #(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2
);
    logic                       valid_in;
    logic                       ready_in;
    logic [NUM_CH*DATA_W-1:0]   audio_in;

    modport master (output valid_in, output audio_in, input ready_in);
    modport slave  (input valid_in, input audio_in, output ready_in);
endinterface
`default_nettype wire

// File: rtl/sdm_dac_mc_mod_core.sv
`default_nettype none
// ============================================================================
// Module      : sdm_mod_core
// Description : One channel of the sigma-delta loop: one or two saturating
//               integrators, +/- full-scale feedback and the 1-bit quantiser.
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : 1 = step the loop this cycle, 0 = hold everything cleared
//   x          : effective signed input sample
//   bit_out    : registered output bit (also the feedback for the next step)
//   sat        : registered flag, an integrator clipped in the last step
// Revision    : 1.0  initial release
// ============================================================================
module sdm_mod_core
    import sdm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ACC_W  = DATA_W + 4,
    parameter int ORDER  = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     run,
    input  logic signed [DATA_W-1:0] x,
    output logic                     bit_out,
    output logic                     sat
);

    localparam longint FS = sdm_fs(DATA_W);

    logic signed [ACC_W-1:0] r_i1;
    logic signed [ACC_W-1:0] r_i2;

    longint w_fb;
    longint w_d1;
    longint w_d2;
    longint w_n1;
    longint w_n2;
    logic   w_bit;
    logic   w_clip;

    always_comb begin
        w_fb   = bit_out ? FS : -FS;
        w_d1   = longint'(x) - w_fb;
        w_n1   = sdm_sat_add(longint'(r_i1), w_d1, ACC_W);
        w_d2   = w_n1 - w_fb;
        w_n2   = sdm_sat_add(longint'(r_i2), w_d2, ACC_W);
        w_clip = (w_n1 != longint'(r_i1) + w_d1);
        w_bit  = (w_n1 >= 0);
        if (ORDER == int'(SDM_ORD2)) begin
            w_clip = w_clip || (w_n2 != longint'(r_i2) + w_d2);
            w_bit  = (w_n2 >= 0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i1    <= '0;
            r_i2    <= '0;
            bit_out <= 1'b0;
            sat     <= 1'b0;
        end else if (!run) begin
            // Outside RUN the loop restarts from zero state and a 0 feedback bit.
            r_i1    <= '0;
            r_i2    <= '0;
            bit_out <= 1'b0;
            sat     <= 1'b0;
        end else begin
            r_i1    <= ACC_W'(w_n1);
            r_i2    <= (ORDER == int'(SDM_ORD2)) ? ACC_W'(w_n2) : '0;
            bit_out <= w_bit;
            sat     <= w_clip;
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdm_dac_mc.sv
`default_nettype none
// ============================================================================
// Module      : sdm_dac_mc
// Description : Multi-channel sigma-delta DAC modulator. Accepts PCM frames
//               over a valid/ready handshake, holds each for OSR modulator
//               cycles and emits one 1-bit stream per channel.
//   clk, rst_n   : clock, asynchronous active-low reset
//   pcm          : frame handshake (valid_in / ready_in / audio_in)
//   mute         : zero the input from the next frame boundary
//   valid_out    : sdm_out carries modulated data
//   sdm_out      : 1-bit stream per channel
//   frame_strobe : a new frame enters the modulator this cycle
//   underrun     : frame boundary with no pending frame (last frame repeats)
//   sat          : per-channel integrator clip flag
// Revision    : 1.0  initial release
// ============================================================================
module sdm_dac_mc
    import sdm_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CH = 2,
    parameter int OSR    = 64,
    parameter int ORDER  = 2,
    parameter int ACC_W  = DATA_W + 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sdm_dac_mc_if.slave       pcm,
    input  logic              mute,
    output logic              valid_out,
    output logic [NUM_CH-1:0] sdm_out,
    output logic              frame_strobe,
    output logic              underrun,
    output logic [NUM_CH-1:0] sat
);

    localparam int             CNT_W    = (OSR > 2) ? $clog2(OSR) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

    generate
        if (ORDER != int'(SDM_ORD1) && ORDER != int'(SDM_ORD2)) begin : g_bad_order
            $error("sdm_dac_mc: ORDER must be 1 or 2");
        end
    endgenerate

    sdm_state_e               r_state;
    sdm_state_e               w_state_nxt;
    logic [CNT_W-1:0]         r_cnt;
    logic [NUM_CH*DATA_W-1:0] r_hold;
    logic [NUM_CH*DATA_W-1:0] r_act;
    logic                     r_hold_full;
    logic                     r_mute_act;
    logic                     w_run;
    logic                     w_boundary;
    logic                     w_load;
    logic                     w_accept;

    // Gated by rst_n so the source never sees ready while the block is in reset.
    assign pcm.ready_in = rst_n && !r_hold_full;

    always_comb begin
        w_run       = (r_state == RUN);
        w_boundary  = w_run && (r_cnt == CNT_LAST);
        w_accept    = pcm.valid_in && !r_hold_full;
        // Load only from the hold register, so a frame accepted in the
        // boundary cycle waits for the following boundary.
        w_load      = r_hold_full && (!w_run || w_boundary);
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (r_hold_full) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign frame_strobe = w_load;
    assign underrun     = w_boundary && !r_hold_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_act       <= '0;
            r_mute_act  <= 1'b0;
            r_cnt       <= '0;
            valid_out   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_hold      <= pcm.audio_in;
                r_hold_full <= 1'b1;
            end else if (w_load) begin
                r_hold_full <= 1'b0;
            end
            if (w_load) begin
                r_act <= r_hold;
            end
            // mute only takes effect on whole frames.
            if (w_load || w_boundary) begin
                r_mute_act <= mute;
            end
            if (!w_run || w_boundary) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            valid_out <= w_run;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [DATA_W-1:0] w_x;
        assign w_x = r_mute_act ? '0 : r_act[c*DATA_W +: DATA_W];

        sdm_mod_core #(
            .DATA_W (DATA_W),
            .ACC_W  (ACC_W),
            .ORDER  (ORDER)
        ) u_core (
            .clk     (clk),
            .rst_n   (rst_n),
            .run     (w_run),
            .x       (w_x),
            .bit_out (sdm_out[c]),
            .sat     (sat[c])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_sdm_dac_mc.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdm_dac_mc
// Description : Testbench for sdm_dac_mc. Two instances (ORDER=1, ORDER=2)
//               share the stimulus; a cycle model predicts every output word,
//               and feature tasks add density/latency/handshake checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sdm_dac_mc;

    localparam int     DW  = 16;
    localparam int     NCH = 2;
    localparam int     OSR = 8;
    localparam int     AW  = DW + 4;
    localparam longint FS  = longint'(1) << (DW - 1);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              tb_valid = 1'b0;
    logic [NCH*DW-1:0] tb_audio = '0;
    logic              tb_mute  = 1'b0;

    sdm_dac_mc_if #(.DATA_W(DW), .NUM_CH(NCH)) bus1 ();
    sdm_dac_mc_if #(.DATA_W(DW), .NUM_CH(NCH)) bus2 ();
    assign bus1.valid_in = tb_valid;
    assign bus2.valid_in = tb_valid;
    assign bus1.audio_in = tb_audio;
    assign bus2.audio_in = tb_audio;

    logic       vo1, vo2, fs1, fs2, ur1, ur2;
    logic [1:0] so1, so2, st1, st2;

    sdm_dac_mc #(.DATA_W(DW), .NUM_CH(NCH), .OSR(OSR), .ORDER(1), .ACC_W(AW)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .pcm(bus1), .mute(tb_mute), .valid_out(vo1),
        .sdm_out(so1), .frame_strobe(fs1), .underrun(ur1), .sat(st1));
    sdm_dac_mc #(.DATA_W(DW), .NUM_CH(NCH), .OSR(OSR), .ORDER(2), .ACC_W(AW)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pcm(bus2), .mute(tb_mute), .valid_out(vo2),
        .sdm_out(so2), .frame_strobe(fs2), .underrun(ur2), .sat(st2));

    // Byte per instance: {ready, valid_out, sdm_out[1:0], sat[1:0], frame_strobe, underrun}
    logic [15:0] obs;
    assign obs = {bus2.ready_in, vo2, so2, st2, fs2, ur2, bus1.ready_in, vo1, so1, st1, fs1, ur1};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_v;

    // ---------------- reference model ----------------
    bit          m_hold_full, m_run, m_mute_act, m_vout;
    int          m_cnt;
    logic [31:0] m_hold, m_act;
    longint      m_i1[2][2];
    longint      m_i2[2][2];
    bit          m_b[2][2];
    bit          m_sat[2][2];

    function automatic longint clipv(longint v);
        longint top;
        top = (longint'(1) << (AW - 1)) - 1;
        if (v > top) return top;
        if (v < -top - 1) return -top - 1;
        return v;
    endfunction

    task automatic model_reset();
        m_hold_full = 0; m_run = 0; m_mute_act = 0; m_vout = 0; m_cnt = 0;
        m_hold = '0; m_act = '0;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < 2; c++) begin
                m_i1[d][c] = 0; m_i2[d][c] = 0; m_b[d][c] = 0; m_sat[d][c] = 0;
            end
        end
        exp_q.delete();
    endtask

    task automatic model_step();
        bit          bnd, load, acc, fs, ur;
        longint      x, fb, s1, n1, s2, n2;
        logic [15:0] e;
        bnd  = m_run && (m_cnt == OSR - 1);
        load = m_hold_full && (!m_run || bnd);
        acc  = tb_valid && !m_hold_full;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NCH; c++) begin
                if (m_run) begin
                    x  = m_mute_act ? 0 : longint'($signed(m_act[c*DW +: DW]));
                    fb = m_b[d][c] ? FS : -FS;
                    s1 = m_i1[d][c] + x - fb;
                    n1 = clipv(s1);
                    m_sat[d][c] = (n1 != s1);
                    if (d == 0) begin
                        m_b[d][c] = (n1 >= 0);
                    end else begin
                        s2 = m_i2[d][c] + n1 - fb;
                        n2 = clipv(s2);
                        m_sat[d][c] = m_sat[d][c] || (n2 != s2);
                        m_b[d][c] = (n2 >= 0);
                        m_i2[d][c] = n2;
                    end
                    m_i1[d][c] = n1;
                end else begin
                    m_i1[d][c] = 0; m_i2[d][c] = 0; m_b[d][c] = 0; m_sat[d][c] = 0;
                end
            end
        end
        m_vout = m_run;
        if (load || bnd) m_mute_act = tb_mute;
        if (load) begin
            m_act = m_hold;
            m_hold_full = 0;
        end
        if (acc) begin
            m_hold = tb_audio;
            m_hold_full = 1;
        end
        m_cnt = (!m_run || bnd) ? 0 : m_cnt + 1;
        if (load) m_run = 1;
        fs = m_hold_full && (!m_run || m_cnt == OSR - 1);
        ur = m_run && (m_cnt == OSR - 1) && !m_hold_full;
        for (int d = 0; d < 2; d++) begin
            e[d*8 +: 8] = {!m_hold_full, m_vout, m_b[d][1], m_b[d][0], m_sat[d][1], m_sat[d][0], fs, ur};
        end
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (obs !== 16'h0000) begin
            errors++; $display("FAIL reset_outputs got=%h want=%h", obs, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== 16'h8080) begin
            errors++; $display("FAIL reset_release got=%h want=%h", obs, 16'h8080);
        end
    endtask

    task automatic test_zero_latency();
        int first_vo = -1;
        int ones = 0;
        int urs = 0;
        tb_audio = '0;
        tb_valid = 1'b1;
        for (int i = 1; i <= 5 * OSR; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL zero_stream cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (vo1 === 1'b1 && first_vo < 0) first_vo = i;
            if (i > OSR) ones += int'(so1[0]);
            urs += int'(ur1);
        end
        checks++;
        if (first_vo !== 3) begin
            errors++; $display("FAIL first_bit_latency got=%0d want=3", first_vo);
        end
        checks++;
        if (ones < 15 || ones > 17) begin
            errors++; $display("FAIL zero_density got=%0d want=16+-1", ones);
        end
        checks++;
        if (urs !== 0) begin
            errors++; $display("FAIL zero_no_underrun got=%0d want=0", urs);
        end
    endtask

    task automatic test_dc_half();
        int n10 = 0, n11 = 0, n20 = 0, n21 = 0;
        tb_audio = {16'hC000, 16'h4000};
        for (int i = 1; i <= 3 * OSR + 64; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL dc_half cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i > 3 * OSR) begin
                n10 += int'(so1[0]); n11 += int'(so1[1]);
                n20 += int'(so2[0]); n21 += int'(so2[1]);
            end
        end
        checks++;
        if (n10 < 47 || n10 > 49) begin errors++; $display("FAIL half_o1_ch0 got=%0d want=48+-1", n10); end
        checks++;
        if (n11 < 15 || n11 > 17) begin errors++; $display("FAIL half_o1_ch1 got=%0d want=16+-1", n11); end
        checks++;
        if (n20 < 45 || n20 > 51) begin errors++; $display("FAIL half_o2_ch0 got=%0d want=48+-3", n20); end
        checks++;
        if (n21 < 13 || n21 > 19) begin errors++; $display("FAIL half_o2_ch1 got=%0d want=16+-3", n21); end
    endtask

    task automatic test_full_scale();
        int sats = 0, n1 = 0, n2 = 0;
        tb_audio = {16'h0000, 16'h7FFF};
        for (int i = 1; i <= 3 * OSR + 64; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL full_scale cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            sats += int'(st2[0]);
            if (i > 3 * OSR) begin
                n1 += int'(so1[0]);
                n2 += int'(so2[0]);
            end
        end
        checks++;
        if (sats == 0) begin errors++; $display("FAIL full_sat_seen got=%0d want=>0", sats); end
        checks++;
        if (n1 < 63) begin errors++; $display("FAIL full_o1_density got=%0d want=>=63", n1); end
        checks++;
        if (n2 < 63) begin errors++; $display("FAIL full_o2_density got=%0d want=>=63", n2); end
    endtask

    task automatic test_underrun();
        int urs = 0, vos = 0;
        tb_valid = 1'b0;
        for (int i = 1; i <= 4 * OSR; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL underrun cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            urs += int'(ur1);
            vos += int'(vo1 && vo2);
        end
        checks++;
        if (urs < 3) begin errors++; $display("FAIL underrun_count got=%0d want=>=3", urs); end
        checks++;
        if (vos !== 4 * OSR) begin errors++; $display("FAIL underrun_valid got=%0d want=%0d", vos, 4 * OSR); end
    endtask

    task automatic test_back_to_back();
        int readies = 0;
        tb_valid = 1'b1;
        for (int i = 1; i <= 6 * OSR; i++) begin
            tb_audio = $urandom();
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL back_to_back cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i > 2 * OSR) readies += int'(bus1.ready_in);
        end
        checks++;
        if (readies !== 4) begin errors++; $display("FAIL accept_rate got=%0d want=4", readies); end
    endtask

    task automatic test_mute_reset();
        int ones = 0;
        int guard = 0;
        tb_audio = {16'h4000, 16'h4000};
        tb_valid = 1'b1;
        for (int i = 1; i <= 3 * OSR; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL pre_mute cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
        end
        while (m_cnt != 3 && guard < 2 * OSR) begin
            tick();
            guard++;
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL align_mute cyc=%0d got=%h want=%h", guard, obs, exp_v);
            end
        end
        tb_mute = 1'b1;
        for (int i = 1; i <= 3 * OSR + 64; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL muted cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
            if (i > 3 * OSR) ones += int'(so1[0]);
        end
        checks++;
        if (ones < 31 || ones > 33) begin errors++; $display("FAIL mute_density got=%0d want=32+-1", ones); end
        // Reset away from any clock edge: outputs must drop without a clock.
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 16'h0000) begin errors++; $display("FAIL async_reset got=%h want=%h", obs, 16'h0000); end
        model_reset();
        tb_mute  = 1'b0;
        tb_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (obs !== 16'h8080) begin errors++; $display("FAIL post_reset_idle got=%h want=%h", obs, 16'h8080); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            exp_v = exp_q.pop_front();
            checks++;
            if (obs !== exp_v) begin
                errors++; $display("FAIL idle_after_reset cyc=%0d got=%h want=%h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_latency();
        test_dc_half();
        test_full_scale();
        test_underrun();
        test_back_to_back();
        test_mute_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdm_dac_mc.md
Name: sdm_dac_mc

Overview:
Parametrised multi-channel sigma-delta DAC modulator. It is the successor to the single-channel fixed first-order DAC path in top.
- Accepts PCM frames (NUM_CH signed samples) over a valid/ready handshake.
- Holds each frame for OSR modulator cycles.
- Emits one 1-bit stream per channel, first- or second-order.
- Sits between the audio sample source and the pad/loopback into the ADC decimator.

Parameters:
DATA_W, 16, signed PCM sample width
NUM_CH, 2, number of independent channels
OSR, 64, modulator cycles per input frame (>=2)
ORDER, 2, loop order, 1 or 2 (any other value is an elaboration error)
ACC_W, DATA_W+4, integrator width (signed, saturating)

Ports:
clk  in  1  system clock; one modulator step per cycle
rst_n  in  1  asynchronous active-low reset
valid_in  in  1  frame on audio_in is valid
ready_in  out  1  block can accept a frame this cycle
audio_in  in  NUM_CH*DATA_W  channel c at bits [c*DATA_W +: DATA_W], two's complement
mute  in  1  force zero input from the next frame boundary
valid_out  out  1  sdm_out carries modulated data
sdm_out  out  NUM_CH  1-bit stream per channel
frame_strobe  out  1  one-cycle pulse when a new frame enters the modulator
underrun  out  1  one-cycle pulse: frame boundary reached with no pending frame
sat  out  NUM_CH  one-cycle pulse per channel: an integrator clipped this cycle

Behaviour:
Reset (async, rst_n=0):
- All registers clear.
- ready_in=0 while in reset.
- valid_out=0, sdm_out=0, frame_strobe=0, underrun=0, sat=0.
- Integrators=0, OSR counter=0, state IDLE.

Buffering: 1-deep holding register (hold, hold_full) plus active register (act).
- ready_in = !hold_full, registered-free (combinational from hold_full).
- Transfer occurs on valid_in && ready_in: hold <= audio_in, hold_full <= 1.

State machine:
- IDLE: integrators held at 0; valid_out=0; sdm_out=0.
  - On hold_full: act <= hold, hold_full <= 0, counter <= 0, frame_strobe pulses, go to RUN.
  - Latency: a frame accepted in cycle t is in act at t+1; its first output bit appears at t+2.
- RUN: every cycle, counter++.
  - At counter==OSR-1 (frame boundary), counter wraps to 0.
  - If hold_full: act <= hold, clear hold_full, pulse frame_strobe.
  - Otherwise act is kept (last frame repeats), underrun pulses, and the block stays in RUN.
  - A transfer into hold in the boundary cycle itself is not seen until the next boundary (no bypass).
  - Simultaneous boundary load and new accept: both occur; hold is refilled the same cycle.
- mute is sampled only at frame boundaries (and at the IDLE->RUN load).
  - When sampled 1, the effective input for the next frame is 0 for all channels.
  - Held frames are not discarded.

Per-channel modulator (RUN only; x = sign-extended effective sample):
- fb = +2^(DATA_W-1) if the previous output bit is 1, else -2^(DATA_W-1). The previous bit is 0 at RUN entry.
- ORDER=1:
  - i1' = sat(i1 + x - fb)
  - bit = (i1' >= 0)
- ORDER=2:
  - i1' = sat(i1 + x - fb)
  - i2' = sat(i2 + i1' - fb)
  - bit = (i2' >= 0)
- Sums are computed at ACC_W+2 bits, then clipped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
- sat[c] pulses in any cycle a clip occurred on channel c.
- sdm_out and valid_out are registered. valid_out=1 for every RUN cycle after the first output bit and remains 1 through underruns.

Reset mid-operation: immediate return to the reset state. Pending and active frames are lost.

Decomposition:
- Package sdm_pkg: ORDER enumeration (SDM_ORD1, SDM_ORD2), state typedef (IDLE, RUN), function for the full-scale feedback constant, saturating-add function.
- Sub-module sdm_mod_core: one channel's integrators, feedback and output bit. Instantiated NUM_CH times in a generate loop.
- The top level owns the handshake, buffering, counter and FSM.

Test Plan:
1. ORDER=1, OSR=64, both channels x=0, continuous valid_in -> after the first bit, sdm_out alternates 1,0,1,0; exactly 32 ones per 64-cycle window. underrun never pulses.
2. ORDER=1, x=+16384 on ch0, x=-16384 on ch1 -> ch0 has 48±1 ones per 64 cycles; ch1 has 16±1. First bit appears 2 cycles after the accept.
3. ORDER=2, x=+32767 for 8 frames -> sat[0] pulses at least once; bit density >= 63/64 with no integrator wrap (no 0-bursts longer than 2).
4. Stop valid_in after one frame -> underrun pulses at cycle 63 of each frame; the last frame repeats; valid_out stays 1.
5. Hold valid_in high with OSR=4 -> ready_in drops after hold fills and rises one cycle after each frame_strobe; exactly one accept per 4 cycles.
6. Assert mute mid-frame, then drop rst_n mid-frame -> input zeroed only from the next boundary (50% density). During reset, all outputs are 0 asynchronously; after release, state is IDLE with ready_in=1.
